lbc_encoder_sched: RTL
======================

Name: lbc_encoder_sched

Overview:
- Round-robin scheduler that shares one 4-byte-in / 38-bit-out linear block encoder datapath between NREQ byte-stream requesters.
- Locks the encoder to one requester for a whole 4-byte frame and drives the byte, phase and write strobe.
- Waits the fixed encoder latency, then captures the 38-bit codeword, tagged with the requester id, into a 2-entry output FIFO with valid/ready.
- Sits between the byte sources and the encoder; downstream backpressure is enforced by credit.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ENC_LAT, 2, cycles from the enc_we of byte 3 to enc_c valid (1..15).
- IDW, clog2(NREQ) (min 1), width of the requester id.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_ready  out  NREQ  per-requester byte accept.
- enc_d  out  8  byte to encoder.
- enc_phase  out  2  byte slot: 0 = codeword bits [37:30], 1 = [29:22], 2 = [21:14], 3 = [13:6].
- enc_we  out  1  encoder byte write strobe.
- enc_c  in  38  encoder codeword: [37:6] data, [5:0] parity.
- cw_valid  out  1  output FIFO non-empty.
- cw_data  out  38  head codeword.
- cw_id  out  IDW  requester id of the head codeword.
- cw_ready  in  1  downstream accept.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous, effective immediately, any state:
  - state = IDLE, rr_ptr = 0, beat = 0, lat_cnt = 0, FIFO empty.
  - req_ready = 0, enc_we = 0, enc_d = 0, enc_phase = 0, cw_valid = 0, cw_data = 0, cw_id = 0, busy = 0.
  - A partial frame is discarded; nothing from it reaches the FIFO.
- Credit: a new frame starts only if fifo_count + inflight < 2. inflight = 1 from the ARB grant until the codeword is captured. The FIFO never overflows and no data is ever dropped.
- FSM IDLE -> ARB -> LOAD -> WAIT -> IDLE.
- IDLE:
  - If any req_valid is high and credit is available, go to ARB next cycle; otherwise stay.
- ARB (1 cycle):
  - grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - Set rr_ptr = g+1 mod NREQ, beat = 0, go to LOAD.
  - If req_valid dropped to all-zero in ARB, return to IDLE with no grant and rr_ptr unchanged.
- LOAD:
  - req_ready[g] = 1; all other req_ready = 0 (combinational from state and g).
  - enc_we = req_valid[g]; enc_d = req_data[g]; enc_phase = beat.
  - Each accepted byte increments beat.
  - The accept with beat = 3 goes to WAIT with lat_cnt = ENC_LAT.
  - A req_valid[g] gap stalls with no timeout and enc_we = 0.
  - Other requesters' req_valid are ignored until the frame completes.
- WAIT:
  - lat_cnt decrements each cycle.
  - On the cycle lat_cnt = 1, push {enc_c, g} into the FIFO, clear inflight, go to IDLE.
  - Codeword capture occurs exactly ENC_LAT cycles after the final enc_we.
- Throughput: 4 + ENC_LAT + 2 cycles per frame minimum (IDLE and ARB each 1 cycle). No overlap of frames.
- FIFO:
  - 2 entries; cw_valid = (count ≠ 0); cw_data and cw_id show the head.
  - Pop on cw_valid & cw_ready.
  - A simultaneous push and pop keeps count unchanged and preserves order.
  - cw_data and cw_id are held stable while cw_valid & !cw_ready.
- Round-robin wrap: rr_ptr = NREQ-1 grant sets rr_ptr = 0.
- A requester holding req_valid continuously with others idle is granted back-to-back frames.

Test Plan:
- Single frame: reset, then requester 0 presents A5, 3C, 0F, F0 on consecutive cycles; stub encoder returns {data, 6'h2B}.
  - enc_phase = 0, 1, 2, 3 with enc_we high on 4 consecutive cycles.
  - Capture ENC_LAT = 2 cycles after the last byte.
  - cw_data = {32'hA53C0FF0, 6'h2B}, cw_id = 0, cw_valid held until cw_ready.
- Round-robin: both requesters valid continuously, 4 frames.
  - Grant order 0, 1, 0, 1; cw_id sequence 0, 1, 0, 1.
  - No byte interleaving between requesters within a frame.
- Stall mid-frame: requester 1 drops req_valid after byte 1 for 3 cycles.
  - enc_we = 0 during the gap; beat holds at 2; the codeword is correct and the id is 1.
  - Requester 0 valid during the gap is not granted.
- Backpressure: cw_ready = 0 with both requesters streaming.
  - Exactly 2 codewords are queued; no further ARB entry, req_ready all 0.
  - Raise cw_ready for 1 cycle: one pop, one new frame starts; no loss or reorder.
- Reset mid-operation: assert rst during LOAD beat 2 and again during WAIT.
  - All outputs are 0 immediately.
  - The next frame after release is granted to requester 0 and produces only its own codeword.
- Simultaneous push/pop: FIFO count = 1, capture and pop in the same cycle.
  - count stays 1; the new codeword appears at the head on the next cycle.

Source files
------------

// File: rtl/lbc_encoder_sched.sv
// Round-robin scheduler sharing one 4-byte-in / 38-bit-out block encoder between NREQ byte streams.
// A frame is locked to one requester; codewords are captured after ENC_LAT and queued in a 2-entry FIFO.
module lbc_encoder_sched #(
  parameter int NREQ    = 2,
  parameter int ENC_LAT = 2,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [7:0]           enc_d,
  output logic [1:0]           enc_phase,
  output logic                 enc_we,
  input  logic [37:0]          enc_c,
  output logic                 cw_valid,
  output logic [37:0]          cw_data,
  output logic [IDW-1:0]       cw_id,
  input  logic                 cw_ready,
  output logic                 busy
);

  // Handshakes: a byte moves when req_valid[i] & req_ready[i]; a codeword leaves when cw_valid & cw_ready.
  typedef enum logic [1:0] {S_IDLE, S_ARB, S_LOAD, S_WAIT} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic [1:0]     beat_q, beat_d;
  logic [3:0]     lat_cnt_q, lat_cnt_d;
  logic           inflight_q, inflight_d;

  logic [37:0]    fifo_data_q [2];
  logic [37:0]    fifo_data_d [2];
  logic [IDW-1:0] fifo_id_q [2];
  logic [IDW-1:0] fifo_id_d [2];
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic [1:0]     count_q, count_d;

  logic [7:0]     req_bytes [NREQ];
  logic           arb_found;
  logic [IDW-1:0] arb_idx;
  logic [IDW-1:0] rr_next;
  logic           credit_ok;
  logic           gnt_valid;
  logic           push;
  logic           pop;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_bytes[i] = req_data[8*i +: 8];
    end
  end

  // First valid requester at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    logic [IDW:0] cand;
    logic [IDW:0] nxt;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!arb_found && req_valid[cand[IDW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IDW-1:0];
      end
    end
    nxt = {1'b0, arb_idx} + (IDW+1)'(1);
    if (nxt == (IDW+1)'(NREQ)) nxt = '0;
    rr_next = nxt[IDW-1:0];
  end

  assign credit_ok = (3'(count_q) + 3'(inflight_q)) < 3'd2;
  assign gnt_valid = req_valid[gnt_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      beat_q     <= '0;
      lat_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      beat_q     <= beat_d;
      lat_cnt_q  <= lat_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    beat_d     = beat_q;
    lat_cnt_d  = lat_cnt_q;
    inflight_d = inflight_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((|req_valid) && credit_ok) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_found) begin
          gnt_d      = arb_idx;
          rr_ptr_d   = rr_next;
          beat_d     = 2'd0;
          inflight_d = 1'b1;
          state_d    = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (gnt_valid) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            lat_cnt_d = 4'(ENC_LAT);
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) begin
          push       = 1'b1;
          inflight_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    enc_we    = 1'b0;
    enc_d     = 8'h00;
    enc_phase = 2'd0;
    busy      = (state_q != S_IDLE);
    if (state_q == S_LOAD) begin
      req_ready[gnt_q] = 1'b1;
      enc_we           = gnt_valid;
      enc_d            = req_bytes[gnt_q];
      enc_phase        = beat_q;
    end
  end

  // Credit guarantees a push never meets a full FIFO.
  assign pop = cw_valid & cw_ready;

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_id_d   = fifo_id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = enc_c;
      fifo_id_d[wr_ptr_q]   = gnt_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_data_q <= '{default: '0};
      fifo_id_q   <= '{default: '0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      fifo_data_q <= fifo_data_d;
      fifo_id_q   <= fifo_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign cw_valid = (count_q != 2'd0);
  assign cw_data  = fifo_data_q[rd_ptr_q];
  assign cw_id    = fifo_id_q[rd_ptr_q];

endmodule
